// File: rtl/simon_btn_conditioner_if.sv
// Debounced button event bundle from simon_btn_conditioner to simon_fsm.
// The conditioner drives it through the master modport; simon_fsm reads it through the slave modport.
interface simon_btn_conditioner_if;
    logic       btn_valid;
    logic [1:0] btn_val;
    logic       btn_held;

    modport master (
        output btn_valid,
        output btn_val,
        output btn_held
    );

    modport slave (
        input btn_valid,
        input btn_val,
        input btn_held
    );
endinterface

// File: rtl/simon_btn_conditioner.sv
// Synchronises and debounces four raw player buttons, emitting one btn_valid pulse per press.
// Optional feature: define BTN_MULTI_REJECT_EN to refuse multi-button candidates.
module simon_btn_conditioner #(
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                            clk_tick,
    input  logic                            reset_n,
    input  logic [3:0]                      btn_raw,
    simon_btn_conditioner_if.master         btn_o
);

    typedef enum logic [1:0] {
        StIdle,
        StArming,
        StPressed,
        StReleasing
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [3:0]       s1_q, s1_d;
    logic [3:0]       sync_q, sync_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic             valid_q, valid_d;
    logic [1:0]       val_q, val_d;
    logic             held_q, held_d;

    // Lowest set index wins.
    function automatic logic [1:0] enc(input logic [3:0] v);
        logic [1:0] r;
        if (v[0]) begin
            r = 2'd0;
        end else if (v[1]) begin
            r = 2'd1;
        end else if (v[2]) begin
            r = 2'd2;
        end else if (v[3]) begin
            r = 2'd3;
        end else begin
            r = 2'd0;
        end
        return r;
    endfunction

`ifdef BTN_MULTI_REJECT_EN
    logic multi;
    assign multi = (sync_q & (sync_q - 4'd1)) != 4'd0;
`endif

    always_comb begin
        s1_d    = btn_raw;
        sync_d  = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        valid_d = 1'b0;
        val_d   = val_q;
        held_d  = held_q;

        case (state_q)
            StIdle: begin
                if (sync_q != 4'd0) begin
                    cand_d  = sync_q;
                    cnt_d   = '0;
                    state_d = StArming;
                end
            end
            StArming: begin
                if (sync_q == 4'd0) begin
                    state_d = StIdle;
                end else if (sync_q != cand_q) begin
                    cand_d = sync_q;
                    cnt_d  = '0;
`ifdef BTN_MULTI_REJECT_EN
                end else if (multi) begin
                    // A chord can never mature into a press.
                    cnt_d = '0;
`endif
                end else if (cnt_q == CntMax) begin
                    state_d = StPressed;
                    valid_d = 1'b1;
                    val_d   = enc(cand_q);
                    held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StPressed: begin
                if (sync_q == 4'd0) begin
                    cnt_d   = '0;
                    state_d = StReleasing;
                end
            end
            StReleasing: begin
                if (sync_q != 4'd0) begin
                    // Release bounce: fall back to the held state silently.
                    cnt_d   = '0;
                    state_d = StPressed;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    held_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_tick or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= '0;
            sync_q  <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= '0;
            valid_q <= 1'b0;
            val_q   <= 2'd0;
            held_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            valid_q <= valid_d;
            val_q   <= val_d;
            held_q  <= held_d;
        end
    end

    assign btn_o.btn_valid = valid_q;
    assign btn_o.btn_val   = val_q;
    assign btn_o.btn_held  = held_q;

endmodule

// File: tb/tb_simon_btn_conditioner.sv
// Scoreboard bench for simon_btn_conditioner: expected pulses (value and cycle) are queued at stimulus
// time and matched against btn_valid on every falling edge.
module tb_simon_btn_conditioner;

    localparam int unsigned DebounceTicks = 4;
    localparam int unsigned Lat           = DebounceTicks + 3;

    typedef struct {
        logic [1:0]  val;
        int unsigned cyc;
    } exp_t;

    logic       clk_tick;
    logic       reset_n;
    logic [3:0] btn_raw;

    simon_btn_conditioner_if btn_if ();

    simon_btn_conditioner #(
        .DEBOUNCE_TICKS(DebounceTicks),
        .CNT_W         (3)
    ) u_dut (
        .clk_tick(clk_tick),
        .reset_n (reset_n),
        .btn_raw (btn_raw),
        .btn_o   (btn_if.master)
    );

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned cyc;
    exp_t        exp_q[$];
    bit          done;

    initial clk_tick = 1'b0;
    always #5 clk_tick = ~clk_tick;

    initial cyc = 0;
    always @(posedge clk_tick) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: a pulse must appear exactly at the queued cycle and nowhere else.
    always @(negedge clk_tick) begin
        if (!done) begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                check("pulse_valid", 32'(btn_if.btn_valid), 32'd1);
                check("pulse_val", 32'(btn_if.btn_val), 32'(exp_q[0].val));
                void'(exp_q.pop_front());
            end else begin
                check("no_pulse", 32'(btn_if.btn_valid), 32'd0);
            end
        end
    end

    task automatic drive(input logic [3:0] v);
        @(negedge clk_tick);
        btn_raw = v;
    endtask

    task automatic expect_pulse(input logic [1:0] v);
        exp_t e;
        e.val = v;
        e.cyc = cyc + Lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_tick);
    endtask

    initial begin
        int unsigned r;
        n_vec   = 0;
        n_err   = 0;
        done    = 1'b0;
        reset_n = 1'b0;
        btn_raw = 4'b1111;

        // 1: outputs quiet throughout reset even with all buttons pressed
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_tick);
            check("rst_valid", 32'(btn_if.btn_valid), 32'd0);
            check("rst_val", 32'(btn_if.btn_val), 32'd0);
            check("rst_held", 32'(btn_if.btn_held), 32'd0);
        end
        btn_raw = 4'b0000;
        @(negedge clk_tick);
        reset_n = 1'b1;
        wait_cyc(3);

        // 2: clean press of colour 2, then release
        drive(4'b0100);
        expect_pulse(2'd2);
        wait_cyc(10);
        check("t2_held", 32'(btn_if.btn_held), 32'd1);
        wait_cyc(9);
        drive(4'b0000);
        wait_cyc(6);
        check("t2_held_pre_fall", 32'(btn_if.btn_held), 32'd1);
        wait_cyc(1);
        check("t2_held_fall", 32'(btn_if.btn_held), 32'd0);
        wait_cyc(3);

        // 3: press bounce, then stable colour 0
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001);
            wait_cyc(1);
            drive(4'b0000);
            wait_cyc(1);
        end
        drive(4'b0001);
        expect_pulse(2'd0);
        wait_cyc(12);
        check("t3_held", 32'(btn_if.btn_held), 32'd1);
        drive(4'b0000);
        wait_cyc(10);
        check("t3_released", 32'(btn_if.btn_held), 32'd0);

        // 4: release glitch must not create a new press
        drive(4'b0001);
        expect_pulse(2'd0);
        wait_cyc(12);
        drive(4'b0000);
        r = cyc;
        wait_cyc(1);
        drive(4'b0001);
        drive(4'b0000);
        wait_cyc(2);
        check("t4_held_glitch", 32'(btn_if.btn_held), 32'd1);
        while (cyc < r + 10 - 1) @(negedge clk_tick);
        check("t4_held_pre_fall", 32'(btn_if.btn_held), 32'd1);
        @(negedge clk_tick);
        check("t4_held_fall", 32'(btn_if.btn_held), 32'd0);
        wait_cyc(3);

        // 5: two-button chord
`ifdef BTN_MULTI_REJECT_EN
        drive(4'b1010);
        wait_cyc(15);
        check("t5_chord_held", 32'(btn_if.btn_held), 32'd0);
        drive(4'b0000);
        wait_cyc(4);
        drive(4'b1000);
        expect_pulse(2'd3);
        wait_cyc(12);
        check("t5_single_held", 32'(btn_if.btn_held), 32'd1);
`else
        drive(4'b1010);
        expect_pulse(2'd1);
        wait_cyc(12);
        check("t5_chord_held", 32'(btn_if.btn_held), 32'd1);
`endif
        drive(4'b0000);
        wait_cyc(10);
        check("t5_released", 32'(btn_if.btn_held), 32'd0);

        // 6: reset while ARMING at cnt=2; press is re-qualified from scratch
        drive(4'b0010);
        wait_cyc(5);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(btn_if.btn_valid), 32'd0);
        check("t6_rst_held", 32'(btn_if.btn_held), 32'd0);
        @(negedge clk_tick);
        reset_n = 1'b1;
        expect_pulse(2'd1);
        wait_cyc(12);
        check("t6_held", 32'(btn_if.btn_held), 32'd1);
        drive(4'b0000);
        wait_cyc(10);
        check("t6_released", 32'(btn_if.btn_held), 32'd0);

        check("pending_pulses", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
